// File: rtl/di_term_router_pkg.sv
// Shared types and constants for the terminal router: FSM states, status bits, default timeout data.
// TIMEOUT state exists only when DI_TERM_ROUTER_TIMEOUT_EN is defined.
package di_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
`ifdef DI_TERM_ROUTER_TIMEOUT_EN
        , TIMEOUT = 2'd3
`endif
    } di_state_e;

    localparam int          STAT_TIMEOUT_BIT  = 1;
    localparam int          STAT_UNMAPPED_BIT = 2;
    localparam logic [15:0] STAT_TIMEOUT      = 16'(1) << STAT_TIMEOUT_BIT;
    localparam logic [15:0] STAT_UNMAPPED     = 16'(1) << STAT_UNMAPPED_BIT;
    localparam logic [15:0] DEF_TIMEOUT_DATA  = 16'hDEAD;

endpackage

// File: rtl/di_term_router_if.sv
// Host-side strobes, per-terminal inputs and routed outputs of the terminal router.
// master = host/terminal side, slave = router.
interface di_term_router_if #(
    parameter int NUM_TERMS = 3
);
    logic [15:0]                 di_term_addr;
    logic                        di_read_req;
    logic                        di_read;
    logic                        di_write;
    logic [NUM_TERMS-1:0][15:0]  term_reg_datao;
    logic [NUM_TERMS-1:0]        term_read_rdy;
    logic [NUM_TERMS-1:0]        term_write_rdy;
    logic [NUM_TERMS-1:0][15:0]  term_transfer_status;
    logic [15:0]                 di_reg_datao;
    logic                        di_read_rdy;
    logic                        di_write_rdy;
    logic [15:0]                 di_transfer_status;
    logic [NUM_TERMS-1:0]        term_sel;
    logic [15:0]                 timeout_count;

    modport master (
        output di_term_addr, di_read_req, di_read, di_write,
               term_reg_datao, term_read_rdy, term_write_rdy, term_transfer_status,
        input  di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status,
               term_sel, timeout_count
    );

    modport slave (
        input  di_term_addr, di_read_req, di_read, di_write,
               term_reg_datao, term_read_rdy, term_write_rdy, term_transfer_status,
        output di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status,
               term_sel, timeout_count
    );
endinterface

// File: rtl/di_term_router_decode.sv
// Address to one-hot terminal match; the lowest channel index wins on duplicate table entries.
module di_term_decode #(
    parameter int                      NUM_TERMS  = 3,
    parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS = '0
) (
    input  logic [15:0]          addr,
    output logic [NUM_TERMS-1:0] sel
);
    // Scan high to low so the lowest matching index is written last.
    always_comb begin
        sel = '0;
        for (int i = NUM_TERMS - 1; i >= 0; i--) begin
            if (addr == TERM_ADDRS[i*16 +: 16]) sel = NUM_TERMS'(1) << i;
        end
    end
endmodule

// File: rtl/di_term_router.sv
// Routes host register accesses to one of NUM_TERMS terminals selected by address.
// DI_TERM_ROUTER_TIMEOUT_EN adds a readiness watchdog, TIMEOUT state and timeout counter.
module di_term_router
    import di_pkg::*;
#(
    parameter int                      NUM_TERMS      = 3,
    parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS     = {16'd2, 16'd1, 16'd0},
    parameter int                      TIMEOUT_CYCLES = 64,
    parameter logic [15:0]             TIMEOUT_DATA   = DEF_TIMEOUT_DATA
) (
    input logic             ifclk,
    input logic             reset,
    di_term_router_if.slave bus
);

    logic [NUM_TERMS-1:0] sel_dec;
    logic [NUM_TERMS-1:0] term_sel_q;
    logic                 sel_chg;
    logic [15:0]          sel_data;
    logic [15:0]          sel_stat;
    logic                 sel_rrdy;
    logic                 sel_wrdy;
    di_state_e            state;
    di_state_e            state_nxt;

    di_term_decode #(
        .NUM_TERMS  (NUM_TERMS),
        .TERM_ADDRS (TERM_ADDRS)
    ) u_decode (
        .addr (bus.di_term_addr),
        .sel  (sel_dec)
    );

    // Selection is changing on this edge; aborts any pending transaction.
    assign sel_chg      = (sel_dec != term_sel_q);
    assign bus.term_sel = term_sel_q;

    always_comb begin
        sel_data = '0;
        sel_stat = STAT_UNMAPPED;
        sel_rrdy = 1'b1;
        sel_wrdy = 1'b1;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (term_sel_q[i]) begin
                sel_data = bus.term_reg_datao[i];
                sel_stat = bus.term_transfer_status[i];
                sel_rrdy = bus.term_read_rdy[i];
                sel_wrdy = bus.term_write_rdy[i];
            end
        end
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            term_sel_q <= '0;
        end else begin
            state      <= state_nxt;
            term_sel_q <= sel_dec;
        end
    end

`ifdef DI_TERM_ROUTER_TIMEOUT_EN
    logic [15:0] wd;
    logic [15:0] tcnt;
    logic        wd_hit;
    logic        in_wait;

    assign in_wait           = (state == WAIT_RD) || (state == WAIT_WR);
    assign wd_hit            = (wd == 16'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_count = tcnt;

    // Watchdog restarts from zero on every entry into a wait state.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            wd   <= '0;
            tcnt <= '0;
        end else begin
            wd <= (in_wait && state_nxt == state) ? wd + 16'd1 : '0;
            if (state_nxt == TIMEOUT && state != TIMEOUT && tcnt != 16'hFFFF)
                tcnt <= tcnt + 16'd1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg        = &{1'b0, bus.di_read, TIMEOUT_DATA, 16'(TIMEOUT_CYCLES)};
    assign bus.timeout_count = '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.di_write)         state_nxt = WAIT_WR;
                else if (bus.di_read_req) state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                if (sel_chg || sel_rrdy) state_nxt = IDLE;
`ifdef DI_TERM_ROUTER_TIMEOUT_EN
                else if (wd_hit)         state_nxt = TIMEOUT;
`endif
            end
            WAIT_WR: begin
                if (sel_chg || sel_wrdy) state_nxt = IDLE;
`ifdef DI_TERM_ROUTER_TIMEOUT_EN
                else if (wd_hit)         state_nxt = TIMEOUT;
`endif
            end
`ifdef DI_TERM_ROUTER_TIMEOUT_EN
            TIMEOUT: begin
                if (bus.di_read || bus.di_write || sel_chg) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.di_reg_datao       = sel_data;
        bus.di_transfer_status = sel_stat;
        bus.di_read_rdy        = sel_rrdy;
        bus.di_write_rdy       = sel_wrdy;
`ifdef DI_TERM_ROUTER_TIMEOUT_EN
        if (state == TIMEOUT) begin
            bus.di_reg_datao       = TIMEOUT_DATA;
            bus.di_transfer_status = sel_stat | STAT_TIMEOUT;
            bus.di_read_rdy        = 1'b1;
            bus.di_write_rdy       = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_di_term_router.sv
// Directed bench for di_term_router; timeout checks follow DI_TERM_ROUTER_TIMEOUT_EN.
module tb_di_term_router;

    logic ifclk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   exp_tc = 0;

`ifdef DI_TERM_ROUTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    always #5 ifclk = ~ifclk;

    di_term_router_if #(.NUM_TERMS(3)) bus ();
    di_term_router_if #(.NUM_TERMS(3)) bus2 ();

    di_term_router #(
        .NUM_TERMS      (3),
        .TERM_ADDRS     ({16'd2, 16'd1, 16'd0}),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (16'hDEAD)
    ) dut (
        .ifclk (ifclk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with duplicate table entries for priority checks.
    di_term_router #(
        .NUM_TERMS      (3),
        .TERM_ADDRS     ({16'd9, 16'd7, 16'd7}),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (16'hDEAD)
    ) dut_dup (
        .ifclk (ifclk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.di_term_addr         = bus.di_term_addr;
    assign bus2.di_read_req          = 1'b0;
    assign bus2.di_read              = 1'b0;
    assign bus2.di_write             = 1'b0;
    assign bus2.term_reg_datao       = bus.term_reg_datao;
    assign bus2.term_read_rdy        = bus.term_read_rdy;
    assign bus2.term_write_rdy       = bus.term_write_rdy;
    assign bus2.term_transfer_status = bus.term_transfer_status;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ifclk);
            #1;
        end
    endtask

    task automatic chk_unmapped(input string tag);
        chk({tag, "_sel"},  32'(bus.term_sel), 32'h0);
        chk({tag, "_data"}, 32'(bus.di_reg_datao), 32'h0);
        chk({tag, "_rrdy"}, 32'(bus.di_read_rdy), 32'h1);
        chk({tag, "_wrdy"}, 32'(bus.di_write_rdy), 32'h1);
        chk({tag, "_stat"}, 32'(bus.di_transfer_status), 32'h0004);
    endtask

    task automatic pulse_read_req();
        bus.di_read_req = 1'b1;
        cyc(1);
        bus.di_read_req = 1'b0;
    endtask

    initial begin
        bus.di_term_addr         = 16'h00FF;
        bus.di_read_req          = 1'b0;
        bus.di_read              = 1'b0;
        bus.di_write             = 1'b0;
        bus.term_reg_datao       = {16'h3333, 16'h2222, 16'h1111};
        bus.term_transfer_status = {16'h0040, 16'h0020, 16'h0010};
        bus.term_read_rdy        = 3'b101;
        bus.term_write_rdy       = 3'b111;

        // reset state
        cyc(2);
        chk_unmapped("rst");
        chk("rst_tc", 32'(bus.timeout_count), 32'h0);
        reset = 1'b0;

        // mapped then unmapped, one-cycle latency
        bus.di_term_addr = 16'd0;
        cyc(1);
        chk("map0_sel",  32'(bus.term_sel), 32'h1);
        chk("map0_data", 32'(bus.di_reg_datao), 32'h1111);
        chk("map0_stat", 32'(bus.di_transfer_status), 32'h0010);
        bus.di_term_addr = 16'h00FF;
        #1;
        chk("unmap_lat", 32'(bus.di_reg_datao), 32'h1111);
        cyc(1);
        chk_unmapped("unmap");

        // duplicate table entries: lowest index wins
        bus.di_term_addr = 16'd7;
        cyc(1);
        chk("dup7_sel", 32'(bus2.term_sel), 32'h1);
        chk("dup7_main", 32'(bus.term_sel), 32'h0);
        bus.di_term_addr = 16'd9;
        cyc(1);
        chk("dup9_sel", 32'(bus2.term_sel), 32'h4);

        // read on term1, ready after 5 cycles
        bus.di_term_addr = 16'd1;
        cyc(1);
        chk("t1_sel", 32'(bus.term_sel), 32'h2);
        pulse_read_req();
        chk("t1_wait_rrdy", 32'(bus.di_read_rdy), 32'h0);
        cyc(4);
        bus.term_read_rdy[1] = 1'b1;
        #1;
        chk("t1_rrdy", 32'(bus.di_read_rdy), 32'h1);
        cyc(1);
        bus.term_read_rdy[1] = 1'b0;
        #1;
        chk("t1_idle_data", 32'(bus.di_reg_datao), 32'h2222);
        chk("t1_idle_rrdy", 32'(bus.di_read_rdy), 32'h0);
        chk("t1_tc", 32'(bus.timeout_count), 32'h0);

        // stuck ready: timeout, or indefinite wait without the watchdog
        pulse_read_req();
        if (TO_EN) begin
            cyc(7);
            chk("to_pre_data", 32'(bus.di_reg_datao), 32'h2222);
            chk("to_pre_rrdy", 32'(bus.di_read_rdy), 32'h0);
            cyc(1);
            exp_tc = 1;
            chk("to_data", 32'(bus.di_reg_datao), 32'hDEAD);
            chk("to_rrdy", 32'(bus.di_read_rdy), 32'h1);
            chk("to_wrdy", 32'(bus.di_write_rdy), 32'h1);
            chk("to_stat", 32'(bus.di_transfer_status), 32'h0022);
            chk("to_tc", 32'(bus.timeout_count), 32'(exp_tc));
            cyc(2);
            chk("to_hold", 32'(bus.di_reg_datao), 32'hDEAD);
            bus.di_read = 1'b1;
            cyc(1);
            bus.di_read = 1'b0;
            #1;
            chk("to_exit_data", 32'(bus.di_reg_datao), 32'h2222);
            chk("to_exit_tc", 32'(bus.timeout_count), 32'(exp_tc));
        end else begin
            cyc(1000);
            chk("nto_rrdy", 32'(bus.di_read_rdy), 32'h0);
            chk("nto_data", 32'(bus.di_reg_datao), 32'h2222);
            chk("nto_tc", 32'(bus.timeout_count), 32'h0);
        end

        // address change mid-wait aborts with no timeout
        bus.di_term_addr = 16'd2;
        cyc(1);
        bus.di_term_addr = 16'd1;
        cyc(1);
        pulse_read_req();
        cyc(2);
        bus.term_read_rdy[2] = 1'b0;
        bus.di_term_addr = 16'd2;
        #1;
        chk("chg_lat", 32'(bus.di_reg_datao), 32'h2222);
        cyc(1);
        chk("chg_sel", 32'(bus.term_sel), 32'h4);
        chk("chg_data", 32'(bus.di_reg_datao), 32'h3333);
        chk("chg_stat", 32'(bus.di_transfer_status), 32'h0040);
        cyc(12);
        chk("chg_nto_data", 32'(bus.di_reg_datao), 32'h3333);
        chk("chg_tc", 32'(bus.timeout_count), 32'(exp_tc));

        // read_req and write together: write wait wins
        bus.di_term_addr = 16'd0;
        bus.term_write_rdy[0] = 1'b0;
        cyc(1);
        bus.di_read_req = 1'b1;
        bus.di_write    = 1'b1;
        cyc(1);
        bus.di_read_req = 1'b0;
        bus.di_write    = 1'b0;
        #1;
        chk("wr_wrdy", 32'(bus.di_write_rdy), 32'h0);
        cyc(8);
        if (TO_EN) begin
            exp_tc = 2;
            chk("wr_to_data", 32'(bus.di_reg_datao), 32'hDEAD);
            chk("wr_to_stat", 32'(bus.di_transfer_status), 32'h0012);
            chk("wr_to_tc", 32'(bus.timeout_count), 32'(exp_tc));
        end
        bus.di_term_addr = 16'd1;
        cyc(1);
        chk("wr_exit_data", 32'(bus.di_reg_datao), 32'h2222);
        chk("wr_exit_tc", 32'(bus.timeout_count), 32'(exp_tc));

        // asynchronous reset mid-transaction
        pulse_read_req();
        cyc(8);
        if (TO_EN) begin
            chk("pre_rst_data", 32'(bus.di_reg_datao), 32'hDEAD);
            chk("pre_rst_tc", 32'(bus.timeout_count), 32'(exp_tc + 1));
        end else begin
            chk("pre_rst_rrdy", 32'(bus.di_read_rdy), 32'h0);
        end
        #2;
        reset = 1'b1;
        #1;
        chk_unmapped("arst");
        chk("arst_tc", 32'(bus.timeout_count), 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_sel", 32'(bus.term_sel), 32'h2);
        cyc(12);
        chk("post_rst_data", 32'(bus.di_reg_datao), 32'h2222);
        chk("post_rst_tc", 32'(bus.timeout_count), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/di_term_router.md
DI_TERM_ROUTER -- requirements
Module: di_term_router

Interface
REQ-001 SHALL have parameter NUM_TERMS, default 3: number of terminal channels, range 1..16.
REQ-002 SHALL have parameter TERM_ADDRS, default {16'd2,16'd1,16'd0}: packed NUM_TERMS x 16-bit table; channel i matches slice i.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: readiness watchdog limit, range 2..65535.
REQ-004 SHALL have parameter TIMEOUT_DATA, default 16'hDEAD: read data substituted on timeout.
REQ-005 SHALL have ports: ifclk input 1 (sole clock); reset input 1 (asynchronous, active-high).
REQ-006 SHALL have ports: di_term_addr input 16; di_read_req input 1; di_read input 1; di_write input 1 (HostInterface strobes).
REQ-007 SHALL have ports: term_reg_datao input 16*NUM_TERMS; term_read_rdy input NUM_TERMS; term_write_rdy input NUM_TERMS; term_transfer_status input 16*NUM_TERMS.
REQ-008 SHALL have ports: di_reg_datao output 16; di_read_rdy output 1; di_write_rdy output 1; di_transfer_status output 16; term_sel output NUM_TERMS (one-hot or zero); timeout_count output 16.

Function
REQ-009 SHALL register term_sel from di_term_addr each ifclk; lowest index wins on duplicate table entries; all-zero when unmapped.
REQ-010 SHALL drive all di_* outputs combinationally from the registered term_sel channel; latency of address change to output: 1 cycle.
REQ-011 Unmapped address SHALL give di_reg_datao=0, both rdy=1, di_transfer_status=16'h0004.
REQ-012 FSM states IDLE, WAIT_RD, WAIT_WR, TIMEOUT; reset state IDLE.
REQ-013 IDLE->WAIT_RD on di_read_req; IDLE->WAIT_WR on di_write; both same cycle: WAIT_WR.
REQ-014 WAIT_RD->IDLE when selected term_read_rdy=1; WAIT_WR->IDLE when selected term_write_rdy=1.
REQ-015 Watchdog counter SHALL clear on entering WAIT_*, increment each WAIT_* cycle, and on reaching TIMEOUT_CYCLES-1 move to TIMEOUT next cycle.
REQ-016 In TIMEOUT: di_read_rdy=di_write_rdy=1, di_reg_datao=TIMEOUT_DATA, di_transfer_status=selected status OR 16'h0002.
REQ-017 TIMEOUT->IDLE on di_read, di_write, or registered term_sel change.
REQ-018 Registered term_sel change while WAIT_* SHALL return FSM to IDLE, no timeout counted.
REQ-019 timeout_count SHALL increment by 1 on each entry to TIMEOUT, saturating at 16'hFFFF.
REQ-020 Outside TIMEOUT, status/data/rdy SHALL be pass-through of selected channel.

Reset
REQ-021 reset SHALL asynchronously set FSM=IDLE, term_sel=0, watchdog=0, timeout_count=0; outputs then equal unmapped values (REQ-011).
REQ-022 Reset mid-WAIT or mid-TIMEOUT SHALL discard the transaction with no timeout_count change.

Configuration
REQ-023 Macro DI_TERM_ROUTER_TIMEOUT_EN defined: watchdog, TIMEOUT state, timeout_count as specified.
REQ-024 Macro undefined: no watchdog; WAIT_* waits indefinitely; timeout_count tied 0; TIMEOUT state absent.

Structure
REQ-025 Shared package di_pkg SHALL hold FSM state typedef, status bit constants (STAT_TIMEOUT=bit1, STAT_UNMAPPED=bit2), default TIMEOUT_DATA.
REQ-026 Sub-module di_term_decode SHALL implement the address-to-one-hot priority match.

Verification
REQ-027 addr=TERM 1, read_req, term1 read_rdy after 5 cycles -> di_read_rdy follows term1, no TIMEOUT, timeout_count=0.
REQ-028 addr=TERM 1, read_rdy stuck 0, TIMEOUT_CYCLES=8 -> TIMEOUT after 8 cycles, datao=16'hDEAD, status bit1=1, timeout_count=1.
REQ-029 addr=16'h00FF unmapped -> one cycle later datao=0, rdy=1/1, status=16'h0004.
REQ-030 read_req then addr change at cycle 3 -> FSM IDLE, timeout_count unchanged, outputs switch to new terminal next cycle.
REQ-031 reset asserted mid-TIMEOUT -> immediate IDLE, term_sel=0, timeout_count=0.
REQ-032 macro undefined, read_rdy stuck 0 for 1000 cycles -> di_read_rdy stays 0, timeout_count=0.
